multicycle_chunk_adder: RTL and testbench

// - Parametrised, multi-cycle successor to the single-bit full adder.
// - Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, carrying between chunks in a register.
// - Trades latency for a short carry chain. Used in the datapath where a full-width ripple misses timing.
// - Valid/ready handshake on input and output; one operation in flight at a time.

---
 rtl/multicycle_chunk_adder_pkg.sv | 15 +
 rtl/multicycle_chunk_adder_chunk.sv | 39 +++
 rtl/multicycle_chunk_adder.sv | 116 +++++++++++
 tb/tb_multicycle_chunk_adder.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_chunk_adder_pkg.sv
// Shared types and helpers for the chunked multi-cycle adder.
package multicycle_chunk_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Chunk index counter width; never narrower than one bit so NCHUNK=1 still has a register.
    function automatic int idx_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/multicycle_chunk_adder_chunk.sv
// Single-bit full adder and the CHUNK-bit combinational ripple built from it.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);
    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module chunk_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             c_in,
    output logic [CHUNK-1:0] sum,
    output logic             c_out,
    output logic             c_msb_in
);
    logic [CHUNK:0] carry;

    assign carry[0] = c_in;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder u_fa (
            .a     (a[i]),
            .b     (b[i]),
            .c_in  (carry[i]),
            .s     (sum[i]),
            .c_out (carry[i+1])
        );
    end

    assign c_out    = carry[CHUNK];
    assign c_msb_in = carry[CHUNK-1];
endmodule

// File: rtl/multicycle_chunk_adder.sv
// Multi-cycle add/subtract: one CHUNK-bit slice per clock with the carry held in a register.
//
// state   | meaning
// IDLE    | waiting for an operand set; in_ready=1
// RUN     | adding chunk idx, carry_reg feeds the next chunk
// DONE    | result presented with out_valid until out_ready
module multicycle_chunk_adder
    import multicycle_chunk_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = idx_width(NCHUNK);
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

    state_t           state;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_l;
    logic [WIDTH-1:0] b_l;
    logic             carry_reg;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] s_chunk;
    logic             chunk_cout;
    logic             chunk_msb_in;

    assign in_ready = (state == ST_IDLE);

    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx == IW'(i)) begin
                a_chunk = a_l[i*CHUNK +: CHUNK];
                b_chunk = b_l[i*CHUNK +: CHUNK];
            end
        end
    end

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .a        (a_chunk),
        .b        (b_chunk),
        .c_in     (carry_reg),
        .sum      (s_chunk),
        .c_out    (chunk_cout),
        .c_msb_in (chunk_msb_in)
    );

    // Operand registers are deliberately left out of reset; they are reloaded on every accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            carry_reg <= 1'b0;
            out_valid <= 1'b0;
            sum       <= '0;
            c_out     <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_l       <= a;
                        b_l       <= b ^ {WIDTH{sub}};
                        carry_reg <= sub | c_in;
                        idx       <= '0;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    for (int i = 0; i < NCHUNK; i++) begin
                        if (idx == IW'(i)) begin
                            sum[i*CHUNK +: CHUNK] <= s_chunk;
                        end
                    end
                    carry_reg <= chunk_cout;
                    if (idx == LAST_IDX) begin
                        idx       <= '0;
                        c_out     <= chunk_cout;
                        ovf       <= chunk_cout ^ chunk_msb_in;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_chunk_adder.sv
// Scoreboard bench: directed 8/4 cases plus random 32-bit traffic at CHUNK 1, 8 and 32.
module tb_multicycle_chunk_adder;

    typedef struct {
        logic [31:0] sum;
        logic        c;
        logic        o;
        int          t_acc;
    } exp_t;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;

    logic clk  = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on 32-bit values.
    function automatic logic [33:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic ci, input logic sub);
        longint m  = longint'(1) << 32;
        longint ua = longint'({32'd0, a});
        longint ub = longint'({32'd0, b});
        longint sa = (ua >= m / 2) ? ua - m : ua;
        longint sb = (ub >= m / 2) ? ub - m : ub;
        longint t;
        longint s;
        logic   c;
        logic   o;
        if (sub) begin
            t = ua - ub;
            c = (ua >= ub);
            s = sa - sb;
        end else begin
            t = ua + ub + longint'(ci);
            c = (t >= m);
            s = sa + sb + longint'(ci);
        end
        if (t < 0) t = t + m;
        if (t >= m) t = t - m;
        o = (s >= m / 2) || (s < -(m / 2));
        return {t[31:0], c, o};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    // ---------------- WIDTH=8, CHUNK=4 instance ----------------
    logic       iv0, ir0, ci0, sub0, ov0, ordy0, co0, of0;
    logic [7:0] a0, b0, s0;
    exp_t       q0[$];
    logic       pv0 = 1'b0;

    multicycle_chunk_adder #(.WIDTH(8), .CHUNK(4)) u_dut8 (
        .clk       (clk),
        .rst       (rst0),
        .in_valid  (iv0),
        .in_ready  (ir0),
        .a         (a0),
        .b         (b0),
        .c_in      (ci0),
        .sub       (sub0),
        .out_valid (ov0),
        .out_ready (ordy0),
        .sum       (s0),
        .c_out     (co0),
        .ovf       (of0)
    );

    always @(negedge clk) begin
        if (!rst0) begin
            if (ov0 && !pv0) begin
                if (q0.size() == 0) begin
                    chk("w8_unexpected_out_valid", 32'(ov0), 32'd0);
                end else begin
                    chk("w8_latency", 32'(cyc - q0[0].t_acc), 32'd2);
                end
            end
            if (ov0 && ordy0 && q0.size() > 0) begin
                exp_t e;
                e = q0.pop_front();
                chk("w8_sum", 32'(s0), e.sum);
                chk("w8_c_out", 32'(co0), 32'(e.c));
                chk("w8_ovf", 32'(of0), 32'(e.o));
            end
        end
        pv0 = ov0;
    end

    // Returns one ns after the accepting edge with in_valid dropped.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sub);
        int g;
        a0 = a; b0 = b; ci0 = ci; sub0 = sub; iv0 = 1'b1;
        g = 0;
        while (!ir0 && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 100) chk("w8_ready_timeout", 32'(ir0), 32'd1);
        @(posedge clk); #1;
        iv0 = 1'b0;
        a0 = 8'($urandom()); b0 = 8'($urandom()); ci0 = 1'($urandom()); sub0 = 1'($urandom());
    endtask

    task automatic drain8();
        int g;
        g = 0;
        while (q0.size() != 0 && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        chk("w8_drain", 32'(q0.size()), 32'd0);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sub,
                       input logic [7:0] es, input logic ec, input logic eo);
        exp_t e;
        issue8(a, b, ci, sub);
        e.sum = 32'(es); e.c = ec; e.o = eo; e.t_acc = cyc;
        q0.push_back(e);
        drain8();
    endtask

    initial begin
        exp_t e;
        int   g;
        iv0 = 1'b0; a0 = '0; b0 = '0; ci0 = 1'b0; sub0 = 1'b0; ordy0 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(ir0), 32'd1);
        chk("rst_out_valid", 32'(ov0), 32'd0);
        chk("rst_sum", 32'(s0), 32'd0);
        chk("rst_c_out", 32'(co0), 32'd0);
        chk("rst_ovf", 32'(of0), 32'd0);
        rst0 = 1'b0;
        rst1 = 1'b0;

        op8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        op8(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        op8(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
        op8(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        op8(8'h03, 8'h01, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0);

        // Backpressure in DONE
        ordy0 = 1'b0;
        issue8(8'h12, 8'h34, 1'b0, 1'b0);
        e.sum = 32'h46; e.c = 1'b0; e.o = 1'b0; e.t_acc = cyc;
        q0.push_back(e);
        g = 0;
        while (!ov0 && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        chk("bp_reach_done", 32'(ov0), 32'd1);
        for (int i = 0; i < 5; i++) begin
            iv0 = 1'b1; a0 = 8'($urandom()); b0 = 8'($urandom()); ci0 = 1'b1; sub0 = 1'b0;
            @(posedge clk); #1;
            chk("bp_sum", 32'(s0), 32'h46);
            chk("bp_c_out", 32'(co0), 32'd0);
            chk("bp_ovf", 32'(of0), 32'd0);
            chk("bp_in_ready", 32'(ir0), 32'd0);
            chk("bp_out_valid", 32'(ov0), 32'd1);
        end
        iv0 = 1'b0;
        ordy0 = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready", 32'(ir0), 32'd1);
        chk("bp_release_out_valid", 32'(ov0), 32'd0);
        chk("bp_popped", 32'(q0.size()), 32'd0);

        // Reset during the second RUN cycle
        issue8(8'h11, 8'h22, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst0 = 1'b1;
        @(posedge clk); #1;
        rst0 = 1'b0;
        chk("abort_in_ready", 32'(ir0), 32'd1);
        chk("abort_out_valid", 32'(ov0), 32'd0);
        chk("abort_sum", 32'(s0), 32'd0);
        repeat (4) begin
            @(posedge clk); #1;
            chk("abort_no_result", 32'(ov0), 32'd0);
        end
        op8(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);

        g = 0;
        while (done_cnt < 3 && g < 20000) begin
            @(posedge clk); #1;
            g++;
        end
        chk("random_blocks_finished", 32'(done_cnt), 32'd3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- WIDTH=32 random instances ----------------
    for (genvar k = 0; k < 3; k++) begin : g_rnd
        localparam int CH = (k == 0) ? 1 : ((k == 1) ? 8 : 32);
        localparam int NC = 32 / CH;

        logic        iv, ir, ci, sb, ov, ordy, co, of;
        logic [31:0] a, b, s;
        exp_t        q[$];
        logic        pv = 1'b0;

        multicycle_chunk_adder #(.WIDTH(32), .CHUNK(CH)) u_dut (
            .clk       (clk),
            .rst       (rst1),
            .in_valid  (iv),
            .in_ready  (ir),
            .a         (a),
            .b         (b),
            .c_in      (ci),
            .sub       (sb),
            .out_valid (ov),
            .out_ready (ordy),
            .sum       (s),
            .c_out     (co),
            .ovf       (of)
        );

        always @(negedge clk) begin
            if (!rst1) begin
                if (ov && !pv) begin
                    if (q.size() == 0) begin
                        chk($sformatf("w32c%0d_unexpected_out_valid", CH), 32'(ov), 32'd0);
                    end else begin
                        chk($sformatf("w32c%0d_latency", CH), 32'(cyc - q[0].t_acc), 32'(NC));
                    end
                end
                if (ov && ordy && q.size() > 0) begin
                    exp_t e;
                    e = q.pop_front();
                    chk($sformatf("w32c%0d_sum", CH), s, e.sum);
                    chk($sformatf("w32c%0d_c_out", CH), 32'(co), 32'(e.c));
                    chk($sformatf("w32c%0d_ovf", CH), 32'(of), 32'(e.o));
                end
            end
            pv = ov;
        end

        initial begin
            int g;
            iv = 1'b0; a = '0; b = '0; ci = 1'b0; sb = 1'b0; ordy = 1'b1;
            wait (rst1 == 1'b0);
            @(posedge clk); #1;
            for (int n = 0; n < 40; n++) begin
                logic [31:0] ta;
                logic [31:0] tb;
                logic        tc;
                logic        ts;
                logic [33:0] r;
                exp_t        e;
                ta = pick(); tb = pick();
                tc = 1'($urandom_range(0, 1)); ts = 1'($urandom_range(0, 1));
                a = ta; b = tb; ci = tc; sb = ts; iv = 1'b1;
                g = 0;
                while (!ir && g < 200) begin
                    @(posedge clk); #1;
                    g++;
                end
                if (g >= 200) chk($sformatf("w32c%0d_ready_timeout", CH), 32'(ir), 32'd1);
                @(posedge clk); #1;
                r = ref_model(ta, tb, tc, ts);
                e.sum = r[33:2]; e.c = r[1]; e.o = r[0]; e.t_acc = cyc;
                q.push_back(e);
                iv = 1'($urandom_range(0, 1));
                a = $urandom(); b = $urandom(); ci = 1'($urandom()); sb = 1'($urandom());
            end
            iv = 1'b0;
            g = 0;
            while (q.size() != 0 && g < 200) begin
                @(posedge clk); #1;
                g++;
            end
            chk($sformatf("w32c%0d_drain", CH), 32'(q.size()), 32'd0);
            done_cnt++;
        end
    end

endmodule
